// File: rtl/relojalarma_pkg.sv
// rtl/relojalarma_pkg.sv - shared seven-segment types and constants for the clock/alarm display path
//
// Purpose : common segment encodings used by every 7-segment consumer.
// Contents: seg_t, SEG_BLANK, SEG_DASH, ANODE_OFF, SEG_TABLE (16 entries).
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package relojalarma_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'b1111111;
  localparam seg_t       SEG_DASH  = 7'b0111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Codes 10..15 are not valid BCD and show a dash so corruption is visible.
  localparam seg_t SEG_TABLE [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_DASH,   SEG_DASH,
    SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD digit to active-low 7-segment decoder
//
// Purpose: map one 4-bit code onto segment lines; invalid BCD shows a dash.
// Ports  : bcd (in, 4 bits)  - digit code
//          seg (out, seg_t)  - active-low {g,f,e,d,c,b,a}
module bcd_to_7seg
  import relojalarma_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/display_scan_4dig.sv
// rtl/display_scan_4dig.sv - time-multiplexed 4-digit common-anode 7-segment scanner
//
// Purpose: snapshot four BCD digits once per frame, scan them onto a
//          multiplexed display with a ghosting blank at each digit switch,
//          and optionally suppress leading zeros.
// Ports  : reloj      (in)      clock, rising edge
//          reseteador (in)      synchronous active-low reset
//          b0..b3     (in, 4)   units .. thousands digits
//          lz_en      (in)      leading-zero suppression enable
//          dp_mask    (in, 4)   per-digit decimal point enables
//          an         (out, 4)  anode enables, active-low
//          seg        (out, 7)  segments {g..a}, active-low
//          dp         (out)     decimal point, active-low
module display_scan_4dig
  import relojalarma_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic       reloj,
  input  logic       reseteador,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  input  logic [3:0] b2,
  input  logic [3:0] b3,
  input  logic       lz_en,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic             s_lz_q, s_lz_d;
  logic [3:0]       s_dp_q, s_dp_d;
  logic [3:0]       an_q, an_d;
  seg_t             seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             slot_end;
  logic [3:0]       digit_sel;
  seg_t             digit_seg;
  logic [3:0]       lz_blank;
  logic             blank;

  assign slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    digit_sel = s0_q;
    case (idx_q)
      2'd0: digit_sel = s0_q;
      2'd1: digit_sel = s1_q;
      2'd2: digit_sel = s2_q;
      2'd3: digit_sel = s3_q;
      default: digit_sel = s0_q;
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (digit_sel),
    .seg (digit_seg)
  );

  // A digit is a leading zero only if it and every higher digit are zero;
  // the units digit always stays lit so a zero value still shows "0".
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (s3_q == 4'd0);
    lz_blank[2] = lz_blank[3] && (s2_q == 4'd0);
    lz_blank[1] = lz_blank[2] && (s1_q == 4'd0);
  end

  assign blank = (cnt_q < CNT_W'(BLANK_CYC)) || (s_lz_q && lz_blank[idx_q]);

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    s0_d   = s0_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    s_lz_d = s_lz_q;
    s_dp_d = s_dp_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      // Capture only at the frame wrap so a frame never mixes two values.
      if (idx_q == 2'd3) begin
        s0_d   = b0;
        s1_d   = b1;
        s2_d   = b2;
        s3_d   = b3;
        s_lz_d = lz_en;
        s_dp_d = dp_mask;
      end
    end
  end

  always_comb begin
    an_d  = ANODE_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ANODE_OFF ^ (4'b0001 << idx_q);
      seg_d = digit_seg;
      dp_d  = ~s_dp_q[idx_q];
    end
  end

  always_ff @(posedge reloj) begin
    if (!reseteador) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      s0_q   <= 4'd0;
      s1_q   <= 4'd0;
      s2_q   <= 4'd0;
      s3_q   <= 4'd0;
      s_lz_q <= 1'b0;
      s_dp_q <= 4'd0;
      an_q   <= ANODE_OFF;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      s_lz_q <= s_lz_d;
      s_dp_q <= s_dp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan_4dig.sv
// tb/tb_display_scan_4dig.sv - self-checking bench for display_scan_4dig
module tb_display_scan_4dig;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;

  logic       reloj = 1'b0;
  logic       reseteador;
  logic [3:0] b0, b1, b2, b3;
  logic       lz_en;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  display_scan_4dig #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .reloj      (reloj),
    .reseteador (reseteador),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .b3         (b3),
    .lz_en      (lz_en),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 reloj = ~reloj;

  logic [6:0] dec_tab [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3f, 7'h3f, 7'h3f, 7'h3f, 7'h3f, 7'h3f
  };

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the k-th edge after reset release sees slot position
  // (k-1)%RD of digit ((k-1)/RD)%4, and the snapshot shown during a frame is
  // whatever was on the inputs at the last edge of the previous frame.
  bit         mvalid = 0;
  int         k;
  logic [3:0] ms [0:3];
  logic       mlz;
  logic [3:0] mdp;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge reloj) begin
    int pos, slot, v;
    bit lit;
    if (!reseteador) begin
      mvalid = 1;
      k = 0;
      for (int i = 0; i < 4; i++) ms[i] = 4'd0;
      mlz = 0;
      mdp = 4'd0;
      exp_an = 4'hf; exp_seg = 7'h7f; exp_dp = 1'b1;
    end else if (mvalid) begin
      k++;
      pos  = (k - 1) % RD;
      slot = ((k - 1) / RD) % 4;
      v    = {ms[3], ms[2], ms[1], ms[0]};
      lit  = (pos >= BC) && !(mlz && slot != 0 && v < (1 << (4 * slot)));
      if (lit) begin
        exp_an  = 4'hf ^ (4'b0001 << slot);
        exp_seg = dec_tab[ms[slot]];
        exp_dp  = ~mdp[slot];
      end else begin
        exp_an = 4'hf; exp_seg = 7'h7f; exp_dp = 1'b1;
      end
      if (k % FRAME == 0) begin
        ms[0] = b0; ms[1] = b1; ms[2] = b2; ms[3] = b3;
        mlz = lz_en;
        mdp = dp_mask;
      end
    end
  end

  always @(negedge reloj) begin
    if (mvalid) begin
      chk("an", an, exp_an);
      chk("seg", seg, exp_seg);
      chk("dp", dp, exp_dp);
      chk("one_anode", ($countones(~an) <= 1), 1);
    end
  end

  int e;

  task automatic adv(input int target);
    while (e < target) begin
      @(posedge reloj);
      e++;
    end
    @(negedge reloj);
  endtask

  task automatic set_digits(input int v3, input int v2, input int v1, input int v0);
    b3 = v3[3:0]; b2 = v2[3:0]; b1 = v1[3:0]; b0 = v0[3:0];
  endtask

  initial begin
    reseteador = 1'b0;
    set_digits(1, 2, 3, 4);
    lz_en = 1'b0;
    dp_mask = 4'b0100;
    repeat (3) @(posedge reloj);
    @(negedge reloj);
    chk("rst_an", an, 4'hf);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_dp", dp, 1);
    reseteador = 1'b1;
    e = 0;
    adv(1);  chk("e1_an", an, 4'hf);
    adv(2);  chk("e2_an", an, 4'hf);
    adv(3);  chk("e3_an", an, 4'he); chk("e3_seg", seg, 7'h40);
    adv(8);  chk("e8_an", an, 4'he);
    adv(9);  chk("e9_an", an, 4'hf);
    adv(34); chk("f1_blank", an, 4'hf);
    adv(35); chk("d0_an", an, 4'he); chk("d0_seg", seg, 7'h19); chk("d0_dp", dp, 1);
    adv(43); chk("d1_an", an, 4'hd); chk("d1_seg", seg, 7'h30);
    set_digits(5, 6, 7, 8);
    adv(51); chk("d2_an", an, 4'hb); chk("d2_seg", seg, 7'h24); chk("d2_dp", dp, 0);
    adv(59); chk("d3_an", an, 4'h7); chk("d3_seg", seg, 7'h79);
    adv(64); chk("d3_end", an, 4'h7);
    adv(67); chk("tear_d0", seg, 7'h00);
    adv(75); chk("tear_d1", seg, 7'h78);
    b1 = 4'hA;
    adv(99);  chk("bad_d0", seg, 7'h00);
    adv(107); chk("bad_d1_an", an, 4'hd); chk("bad_d1_seg", seg, 7'h3f);
    lz_en = 1'b1;
    set_digits(0, 1, 0, 0);
    adv(117);
    reseteador = 1'b0;
    adv(118); chk("mid_rst_an", an, 4'hf);
    reseteador = 1'b1;
    e = 0;
    adv(2);  chk("r2_an", an, 4'hf);
    adv(3);  chk("r3_an", an, 4'he); chk("r3_seg", seg, 7'h40);
    adv(35); chk("lz_d0", seg, 7'h40);
    adv(43); chk("lz_d1_an", an, 4'hd); chk("lz_d1_seg", seg, 7'h40);
    adv(51); chk("lz_d2_an", an, 4'hb); chk("lz_d2_seg", seg, 7'h79);
    adv(59); chk("lz_d3_an", an, 4'hf);
    adv(62); chk("lz_d3_end", an, 4'hf);

    for (int c = 0; c < 4000; c++) begin
      @(negedge reloj);
      if ($urandom_range(0, 19) == 0) begin
        b0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        b1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        b2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        b3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        lz_en = 1'($urandom_range(0, 1));
        dp_mask = 4'($urandom_range(0, 15));
      end
      reseteador = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
    end
    reseteador = 1'b1;
    repeat (2) @(negedge reloj);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
